// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, buffers {pc, instr} pairs for decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign_exc
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [31:0]   fpc_q, fpc_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [0:0]    state_q, state_d;
  logic [31:0]   pcs_q    [FIFO_DEPTH];
  logic [31:0]   instrs_q [FIFO_DEPTH];

  logic        pop, push, misaligned;
  logic [31:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = redirect_pc;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
  // Without the trap, misaligned targets are silently aligned down.
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign target          = {redirect_pc[31:2], 2'b00};
  assign misaligned      = 1'b0;
`endif

  assign iaddr        = fpc_q;
  assign out_valid    = (cnt_q != '0);
  assign out_pc       = out_valid ? pcs_q[rd_q]    : '0;
  assign out_instr    = out_valid ? instrs_q[rd_q] : NOP;
  assign misalign_exc = (state_q == HALT);
  assign pop          = out_valid && out_ready;

  always_comb begin
    fpc_d   = fpc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    push    = 1'b0;
    if (redirect_valid) begin
      // A concurrent pop is still a completed transfer; the flush discards the rest.
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
      if (misaligned) begin
        state_d = HALT;
      end else begin
        state_d = RUN;
        fpc_d   = target;
      end
    end else begin
      push = (state_q == RUN) && ((cnt_q < DEPTH_C) || pop);
      if (push) begin
        wr_d  = wr_q + 1'b1;
        fpc_d = fpc_q + 32'd4;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc_q   <= RESET_PC;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      state_q <= RUN;
    end else begin
      fpc_q   <= fpc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      pcs_q[wr_q]    <= fpc_q;
      instrs_q[wr_q] <= idata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory word at byte address 4n holds n.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iaddr, idata, redirect_pc, out_pc, out_instr;
  logic        redirect_valid, out_valid, out_ready, misalign_exc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .iaddr(iaddr), .idata(idata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;
  assign idata = {2'b00, iaddr[31:2]};

  typedef struct {
    logic        rst_n, rdy, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, ein, eia;
    logic        emis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ev, logic [31:0] epc, logic [31:0] ein, logic [31:0] eia,
                              logic emis, logic r, logic rdy, logic rv, logic [31:0] rpc);
    vec_t v;
    v.ev = ev; v.epc = epc; v.ein = ein; v.eia = eia; v.emis = emis;
    v.rst_n = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] ein, input logic [31:0] eia, input logic emis);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    check({tag, ".pc"}, out_pc, epc);
    check({tag, ".instr"}, out_instr, ein);
    check({tag, ".iaddr"}, iaddr, eia);
    check({tag, ".misalign"}, {31'd0, misalign_exc}, {31'd0, emis});
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    // Each row: expected outputs now, then inputs driven into the next edge.
    vecs.push_back(mk(0, 32'h0,        NOP,          32'h0,        0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0,        32'h0,        32'h4,        0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0,        32'h0,        32'h8,        0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0,        32'h0,        32'h8,        0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0,        32'h0,        32'h8,        0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0,        32'h0,        32'h8,        0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h4,        32'h1,        32'hC,        0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h8,        32'h2,        32'h10,       0, 1, 1, 1, 32'h100));
    vecs.push_back(mk(0, 32'h0,        NOP,          32'h100,      0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h100,      32'h40,       32'h104,      0, 1, 1, 1, 32'hFFFF_FFF8));
    vecs.push_back(mk(0, 32'h0,        NOP,          32'hFFFF_FFF8, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'hFFFF_FFF8, 32'h3FFF_FFFE, 32'hFFFF_FFFC, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0,     0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h0,        32'h0,        32'h4,        0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0,        32'h0,        32'h8,        0, 0, 0, 1, 32'h300));
    vecs.push_back(mk(0, 32'h0,        NOP,          32'h0,        0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h0,        32'h0,        32'h4,        0, 1, 1, 1, 32'h102));
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 32'h0,        NOP,          32'h4,        1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 32'h0,        NOP,          32'h4,        1, 1, 1, 1, 32'h200));
`else
    vecs.push_back(mk(0, 32'h0,        NOP,          32'h100,      0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h100,      32'h40,       32'h104,      0, 1, 1, 1, 32'h200));
`endif
    vecs.push_back(mk(0, 32'h0,        NOP,          32'h200,      0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h200,      32'h80,       32'h204,      0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h204,      32'h81,       32'h208,      0, 1, 1, 1, 32'h400));
    vecs.push_back(mk(0, 32'h0,        NOP,          32'h400,      0, 1, 1, 1, 32'h500));
    vecs.push_back(mk(0, 32'h0,        NOP,          32'h500,      0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h500,      32'h140,      32'h504,      0, 1, 1, 0, 0));

    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tick();
    tick();

    foreach (vecs[i]) begin
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ein,
                 vecs[i].eia, vecs[i].emis);
      rst_n          = vecs[i].rst_n;
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      tick();
    end

    // Steady stream: one instruction per cycle with no gaps.
    for (int k = 1; k <= 8; k++) begin
      check_outs($sformatf("stream%0d", k), 1'b1, 32'h500 + 32'(4 * k),
                 32'h140 + 32'(k), 32'h504 + 32'(4 * k), 1'b0);
      tick();
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect while halted keeps the stage halted.
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    check_outs("halt_stay", 1'b0, 32'h0, NOP, 32'h528, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    check_outs("halt_exit", 1'b0, 32'h0, NOP, 32'h10, 1'b0);
    tick();
    check_outs("halt_resume", 1'b1, 32'h10, 32'h4, 32'h14, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the memory's combinational byte address (iaddr); the memory returns the 32-bit instruction (idata) in the same cycle.
- Captures each {pc, instruction} pair into a small FIFO and hands it to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, legal range 2..8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- iaddr  out  32  byte address to instruction memory; equals the fetch PC register.
- idata  in  32  instruction word from instruction memory, valid in the same cycle as iaddr.
- redirect_valid  in  1  redirect request from execute (taken branch/jump).
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  head FIFO entry valid.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- misalign_exc  out  1  misaligned redirect flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n), sampled on rising clk.
- Reset values:
  - fpc=RESET_PC, FIFO empty (count=0, pointers 0), state=RUN.
  - out_valid=0, out_pc=0, out_instr=32'h0000_0013 (NOP), misalign_exc=0.
  - Reset mid-operation discards all FIFO contents and any pending redirect.
- Outputs:
  - iaddr = fpc, combinational.
  - out_* are driven from FIFO storage only; there is no combinational path from idata to out_*.
  - When the FIFO is empty: out_pc=0, out_instr=NOP.
- Pop: occurs when out_valid && out_ready.
- Push condition: state==RUN && !redirect_valid && (count<FIFO_DEPTH || pop).
  - Push writes {fpc, idata} at the tail and sets fpc <= fpc+4.
  - Simultaneous push and pop on a full FIFO is allowed; count is unchanged.
  - Push with no pop: count+1. Pop with no push: count-1.
- Full FIFO with no pop: no push, fpc holds, iaddr is stable.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, modulo 2^32, no flag.
- Redirect (highest priority, below reset):
  - A pop in the same cycle is a completed transfer.
  - FIFO is cleared next cycle (count=0) and fpc <= redirect_pc.
  - No push occurs in the redirect cycle.
  - Cycle after redirect: out_valid=0, iaddr=target.
  - Following cycle: out_valid=1 with out_pc=target.
- Startup latency: first cycle after rst_n rises pushes RESET_PC; out_valid=1 on the next cycle. Redirect-to-valid latency is also 2 cycles.
- Steady state: one instruction per cycle when out_ready is held high.
- out_valid, once asserted, stays high with out_pc/out_instr stable until popped or flushed by redirect.
- Back-to-back redirects: the last one wins; each one flushes.
- States:
  - RUN: normal fetching.
  - HALT: exists only with the optional feature. No pushes, fpc holds, FIFO empty. Exit to RUN only on an aligned redirect, or on reset.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - redirect_valid with redirect_pc[1:0]!=0 flushes the FIFO, leaves fpc unchanged, and enters HALT.
  - misalign_exc=1 (registered) while in HALT.
  - An aligned redirect in HALT loads fpc, clears misalign_exc next cycle, and returns to RUN.
  - A misaligned redirect while in HALT stays in HALT.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 (target aligned down).
  - No HALT state exists and misalign_exc is tied to 0.

Test Plan:
- Reset and stream: rst_n low 2 cycles, RESET_PC=0, memory word at addr 4n = n, out_ready=1 -> out_valid rises 2 cycles after rst_n high; out_pc sequence 0,4,8,... with out_instr 0,1,2,... one per cycle, no gaps.
- Backpressure: out_ready=0 for 5 cycles after the first valid, FIFO_DEPTH=2 -> out_pc holds 0, iaddr stalls at 8 with count=2; on out_ready=1, out_pc resumes 4, 8, 12 with no loss or duplication.
- Redirect with pop: redirect_valid=1, redirect_pc=32'h100, in the same cycle as a pop of pc 8 -> pc 8 counts as accepted; next cycle out_valid=0, iaddr=32'h100; following cycle out_pc=32'h100.
- PC wrap: redirect to 32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Mid-stream reset: rst_n low for 1 cycle while the FIFO is full -> next cycle out_valid=0, iaddr=RESET_PC, out_instr=NOP.
- Misalign: redirect_pc=32'h102:
  - FETCH_MISALIGN_TRAP_EN defined: misalign_exc=1 and out_valid stays 0; a later redirect to 32'h200 clears misalign_exc and gives out_pc=32'h200.
  - Undefined: out_pc=32'h100 and misalign_exc=0.
